keypad_encoder: RTL
===================

# keypad_encoder

Front-panel entry block for the microwave controller: scans the ten decimal cooking-time keys, synchronises and debounces them, encodes the accepted key to BCD, and shifts it into a three-digit M:SS time register. The `min`/`s_tens`/`s_ones` outputs feed the 7-segment display decoder and the countdown timer's preset load. This is the input-side counterpart of the display path: one-hot key events in, BCD digits out.

## Interface
- `DEBOUNCE_CYCLES`, default 4 — consecutive stable synchronised samples required to accept a key; must be ≥ 2.
- `clk`  in  1  — sole clock; all state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `keypad`  in  10  — raw keys, bit i = digit key i, active-high, asynchronous to `clk`.
- `clear`  in  1  — synchronous clear of the entered time to 0:00.
- `lock`  in  1  — high while cooking; accepted keys are discarded.
- `min`  out  4  — minutes digit, BCD 0–9.
- `s_tens`  out  4  — seconds-tens digit, BCD 0–5.
- `s_ones`  out  4  — seconds-ones digit, BCD 0–9.
- `digit_valid`  out  1  — one-cycle pulse when a digit is shifted in.
- `key_reject`  out  1  — one-cycle pulse when an accepted key is refused because of the range check.

## Operation
- Reset values: all digits 0, `digit_valid` = 0, `key_reject` = 0, FSM in IDLE, synchroniser flops 0, debounce counter 0.
- `keypad` passes through a 2-flop synchroniser. All decisions use the synchronised value `ks`.
- IDLE: if `ks` has exactly one bit set, capture that one-hot pattern, set count to 1, and go to DEBOUNCE. A value of zero or more than one set bit keeps the FSM in IDLE.
- DEBOUNCE: if `ks` equals the captured pattern, increment the count. When the count is DEBOUNCE_CYCLES−1 and `ks` still matches, go to ACCEPT. Any mismatch, including a second key or release, returns the FSM to IDLE.
- ACCEPT (one cycle), resolved in this priority order:
  - If `clear` is high: digits become 0; no pulse.
  - Else if `lock` is high: the key is discarded; no pulse.
  - Else if `s_ones` > 5: the digits are unchanged and `key_reject` = 1.
  - Otherwise the digits shift: `min` ← `s_ones`… specifically `min` ← `s_tens`, `s_tens` ← `s_ones`, `s_ones` ← key code, and `digit_valid` = 1. The old `min` is dropped.
  - In all cases the FSM then goes to RELEASE.
- RELEASE: stay until `ks` is all zero, then go to IDLE. A held key therefore produces exactly one event.
- `clear` in any state forces the digits to 0 on the next edge and does not change the FSM state.
- Invariant: the outputs are always legal BCD with `s_tens` ≤ 5.

## Timing
- A key that is stable from edge 1 is first seen by the FSM at edge 3. The digits update, and the pulse is registered, at edge DEBOUNCE_CYCLES+3. With the default of 4 this is the 7th rising edge.
- `digit_valid` and `key_reject` are registered, last exactly one cycle, and are mutually exclusive.
- Minimum spacing between two accepted keys: release seen, plus a full debounce of the next key.
- `rst` asserted mid-debounce or mid-RELEASE: reset values apply on the next edge. A key still held after reset must pass a full debounce before it is accepted.
- `clear` and `rst` on the same edge: reset applies.

## Structure
- Shared package `keypad_pkg`, containing:
  - FSM state encoding (IDLE, DEBOUNCE, ACCEPT, RELEASE);
  - `MAX_S_TENS` = 5;
  - a one-hot-to-BCD encode function;
  - the default debounce constant.
- One sub-module `sync_2ff` (a 10-bit two-flop synchroniser), reusable for the other front-panel buttons.
- The debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits wide and saturates.

## Test plan
- Press 1, 3, 0 in sequence, each held for 10 cycles, with `lock` = 0 → digits 1:30, three `digit_valid` pulses, the first at edge 7 of key 1.
- Key 5 glitching for 2 cycles, then released → no change, no pulse. Keys 2 and 7 held simultaneously → no event.
- From 0:07, press 8 → `key_reject` pulse, digits remain 0:07. From 0:05, press 8 → 0:58.
- Hold key 4 for 50 cycles → exactly one `digit_valid`. `lock` = 1 during ACCEPT → no change, no pulse.
- `clear` asserted on the same edge as ACCEPT → 0:00, no pulse. `rst` pulsed mid-DEBOUNCE with the key still held → 0:00, then a full debounce before the key is accepted.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the front-panel keypad path: FSM encoding,
// seconds-tens limit, default debounce length and key encode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        ACCEPT   = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

    localparam logic [3:0]  MAX_S_TENS       = 4'd5;
    localparam int unsigned DEBOUNCE_DEFAULT = 4;

    // True when exactly one key bit is set.
    function automatic logic is_onehot(input logic [9:0] keys);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (keys[i]) ones++;
        end
        return (ones == 1);
    endfunction

    // One-hot key pattern to BCD digit; only meaningful for one-hot input.
    function automatic logic [3:0] onehot_to_bcd(input logic [9:0] keys);
        logic [3:0] code;
        code = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (keys[i]) code = 4'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous front-panel inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the raw inputs into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad scan front end: synchronise, debounce, encode to BCD and shift
// accepted digits into the M:SS cooking-time register.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keypad,
    input  logic       clear,
    input  logic       lock,
    output logic [3:0] min,
    output logic [3:0] s_tens,
    output logic [3:0] s_ones,
    output logic       digit_valid,
    output logic       key_reject
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    key_state_t    state, state_next;
    logic [9:0]    ks;
    logic [9:0]    cap, cap_next;
    logic [CW-1:0] cnt, cnt_next;

    sync_2ff #(.WIDTH(10)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (keypad),
        .q   (ks)
    );

    // FSM state, captured key pattern and debounce count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cap   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cap   <= cap_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: capture a single key, require it stable, then wait for release.
    always_comb begin
        state_next = state;
        cap_next   = cap;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (is_onehot(ks)) begin
                    cap_next   = ks;
                    cnt_next   = CW'(1);
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (ks == cap) begin
                    if (cnt == LAST_COUNT) begin
                        state_next = ACCEPT;
                    end else if (cnt != '1) begin
                        cnt_next = cnt + CW'(1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            ACCEPT: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                if (ks == '0) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Time register and event pulses; clear wins, then lock, then the range check.
    always_ff @(posedge clk) begin
        if (rst) begin
            min         <= '0;
            s_tens      <= '0;
            s_ones      <= '0;
            digit_valid <= 1'b0;
            key_reject  <= 1'b0;
        end else begin
            digit_valid <= 1'b0;
            key_reject  <= 1'b0;
            if (clear) begin
                min    <= '0;
                s_tens <= '0;
                s_ones <= '0;
            end else if (state == ACCEPT && !lock) begin
                // s_ones moves into s_tens, so it must not exceed the seconds-tens limit
                if (s_ones > MAX_S_TENS) begin
                    key_reject <= 1'b1;
                end else begin
                    min         <= s_tens;
                    s_tens      <= s_ones;
                    s_ones      <= onehot_to_bcd(cap);
                    digit_valid <= 1'b1;
                end
            end
        end
    end

endmodule
